// File: rtl/tap_pkg.sv
// Shared tape timing constants, derived recorder thresholds and FSM state type.
// The player imports the same package so both sides agree on pulse widths.
package tap_pkg;

  localparam int unsigned W_BITS = 13;

  // Nominal ROM pulse widths in 3.5 MHz cycles.
  localparam int unsigned T_PILOT      = 2168;
  localparam int unsigned T_SYNC1      = 667;
  localparam int unsigned T_SYNC2      = 735;
  localparam int unsigned T_BIT0       = 855;
  localparam int unsigned T_BIT1       = 1710;
  localparam int unsigned PILOT_HEADER = 8063;
  localparam int unsigned PILOT_DATA   = 3223;

  // Recorder classification thresholds.
  localparam int unsigned PILOT_LO  = 1940;
  localparam int unsigned PILOT_HI  = 2600;
  localparam int unsigned PILOT_MIN = 256;
  localparam int unsigned SYNC_MAX  = 790;
  localparam int unsigned BIT_THR   = 2565;
  localparam int unsigned TIMEOUT   = 7000;

  typedef enum logic [2:0] {
    StIdle,
    StPilot,
    StSync2,
    StBitH1,
    StBitH2,
    StLenLo,
    StLenHi,
    StDone
  } rec_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [W_BITS-1:0] sat_inc13(input logic [W_BITS-1:0] v);
    return (v == '1) ? v : v + 13'd1;
  endfunction

endpackage

// File: rtl/tap_pulse_meter.sv
// MIC front end: 2-FF synchroniser, both-polarity edge detect and a saturating
// half-period counter presented as width_o on every edge.
module tap_pulse_meter
  import tap_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mic_in,
  output logic              edge_o,
  output logic [W_BITS-1:0] width_o
);

  logic              sync1_q, sync2_q, prev_q;
  logic [W_BITS-1:0] h_q, h_d;

  assign edge_o  = sync2_q ^ prev_q;
  assign width_o = h_q;

  always_comb begin
    h_d = sat_inc13(h_q);
    if (edge_o) h_d = 13'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      h_q     <= '0;
    end else begin
      sync1_q <= mic_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      h_q     <= h_d;
    end
  end

endmodule

// File: rtl/tap_recorder.sv
// Tape recorder: classifies MIC half-periods into pilot/sync/bits and stores
// each block in TAP layout (2-byte LE length, then data) in tape memory.
module tap_recorder
  import tap_pkg::*;
#(
  parameter int unsigned PilotLo   = PILOT_LO,
  parameter int unsigned PilotHi   = PILOT_HI,
  parameter int unsigned PilotMin  = PILOT_MIN,
  parameter int unsigned SyncMax   = SYNC_MAX,
  parameter int unsigned BitThr    = BIT_THR,
  parameter int unsigned Timeout   = TIMEOUT,
  parameter logic [15:0] BaseReset = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rec,
  input  logic        mic_in,
  output logic [15:0] wr_address,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        block_done,
  output logic [15:0] block_len
);

  localparam logic [W_BITS-1:0] PilotLoW  = W_BITS'(PilotLo);
  localparam logic [W_BITS-1:0] PilotHiW  = W_BITS'(PilotHi);
  localparam logic [W_BITS-1:0] PilotMinW = W_BITS'(PilotMin);
  localparam logic [W_BITS-1:0] SyncMaxW  = W_BITS'(SyncMax);
  localparam logic [W_BITS-1:0] TimeoutW  = W_BITS'(Timeout);
  localparam logic [W_BITS:0]   BitThrW   = (W_BITS + 1)'(BitThr);

  logic              mic_edge;
  logic [W_BITS-1:0] width;

  tap_pulse_meter u_meter (
    .clock   (clock),
    .reset_n (reset_n),
    .mic_in  (mic_in),
    .edge_o  (mic_edge),
    .width_o (width)
  );

  rec_state_e        state_q, state_d;
  logic [15:0]       base_q, base_d, ptr_q, ptr_d, cnt_q, cnt_d;
  logic [W_BITS-1:0] pc_q, pc_d, h1_q, h1_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bitn_q, bitn_d;
  logic [15:0]       wr_addr_q, wr_addr_d, len_q, len_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;

  logic              in_range, is_sync, end_blk, close_blk, bit_val;
  logic [W_BITS:0]   bit_sum;
  logic [7:0]        new_sh;

  always_comb begin
    in_range = (width >= PilotLoW) && (width <= PilotHiW);
    is_sync  = width < SyncMaxW;
    end_blk  = (!mic_edge && (width >= TimeoutW)) || !rec;
    bit_sum  = {1'b0, h1_q} + {1'b0, width};
    bit_val  = bit_sum > BitThrW;
    new_sh   = {sh_q[6:0], bit_val};

    state_d   = state_q;
    base_d    = base_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    h1_d      = h1_q;
    sh_d      = sh_q;
    bitn_d    = bitn_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    len_d     = len_q;
    close_blk = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rec && mic_edge && in_range) begin
          state_d = StPilot;
          pc_d    = 13'd1;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StPilot: begin
        if (end_blk) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (mic_edge) begin
          if (in_range) begin
            pc_d = sat_inc13(pc_q);
          end else if (is_sync && (pc_q >= PilotMinW)) begin
            state_d = StSync2;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
      end
      StSync2: begin
        if (end_blk) begin
          close_blk = 1'b1;
        end else if (mic_edge) begin
          if (is_sync) begin
            state_d = StBitH1;
            bitn_d  = 3'd7;
            ptr_d   = base_q + 16'd2;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
      end
      StBitH1: begin
        if (end_blk) begin
          close_blk = 1'b1;
        end else if (mic_edge) begin
          h1_d    = width;
          state_d = StBitH2;
        end
      end
      StBitH2: begin
        if (end_blk) begin
          close_blk = 1'b1;
        end else if (mic_edge) begin
          sh_d    = new_sh;
          bitn_d  = bitn_q - 3'd1;
          state_d = StBitH1;
          if (bitn_q == 3'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = new_sh;
            ptr_d     = ptr_q + 16'd1;
            cnt_d     = sat_inc16(cnt_q);
          end
        end
      end
      StLenLo: begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_q + 16'd1;
        wr_data_d = cnt_q[15:8];
        state_d   = StLenHi;
      end
      StLenHi: begin
        done_d  = 1'b1;
        len_d   = cnt_q;
        base_d  = ptr_q;
        busy_d  = 1'b0;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The LEN_LO write is issued here so it lands in the cycle after the timeout.
    if (close_blk) begin
      if (cnt_q != 16'd0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_q;
        wr_data_d = cnt_q[7:0];
        state_d   = StLenLo;
      end else begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      base_q    <= BaseReset;
      ptr_q     <= '0;
      cnt_q     <= '0;
      pc_q      <= '0;
      h1_q      <= '0;
      sh_q      <= '0;
      bitn_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      h1_q      <= h1_d;
      sh_q      <= sh_d;
      bitn_q    <= bitn_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_q     <= len_d;
    end
  end

  assign wr_address = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign busy       = busy_q;
  assign block_done = done_q;
  assign block_len  = len_q;

endmodule

// File: tb/tb_tap_recorder.sv
// Directed bench for tap_recorder using time-scaled thresholds (pilot 217,
// sync 67/74, bits 86/171) so whole blocks fit in a short run.
module tb_tap_recorder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rec = 1'b0, mic = 1'b1;
  logic rec_w = 1'b0, mic_w = 1'b1;

  logic [15:0] wr_address, block_len, wr_address_w, block_len_w;
  logic [7:0]  wr_data, wr_data_w;
  logic        wr_en, busy, block_done, wr_en_w, busy_w, block_done_w;

  tap_recorder #(
    .PilotLo(194), .PilotHi(260), .PilotMin(8), .SyncMax(79), .BitThr(256), .Timeout(700),
    .BaseReset(16'h0000)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rec(rec), .mic_in(mic),
    .wr_address(wr_address), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .block_done(block_done), .block_len(block_len)
  );

  tap_recorder #(
    .PilotLo(194), .PilotHi(260), .PilotMin(8), .SyncMax(79), .BitThr(256), .Timeout(700),
    .BaseReset(16'hFFFD)
  ) dut_w (
    .clock(clock), .reset_n(reset_n), .rec(rec_w), .mic_in(mic_w),
    .wr_address(wr_address_w), .wr_data(wr_data_w), .wr_en(wr_en_w), .busy(busy_w),
    .block_done(block_done_w), .block_len(block_len_w)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [23:0] log_q[$];
  int          log_cyc[$];
  logic [23:0] logw_q[$];
  int          done_cnt = 0, done_cyc = 0;
  int          checks = 0, failures = 0;

  always @(negedge clock) begin
    if (wr_en) begin
      log_q.push_back({wr_address, wr_data});
      log_cyc.push_back(cyc);
    end
    if (block_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (wr_en_w) logw_q.push_back({wr_address_w, wr_data_w});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 24'hxxxxxx;
  endfunction

  function automatic logic [23:0] logw_at(input int i);
    return (i < logw_q.size()) ? logw_q[i] : 24'hxxxxxx;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -100;
  endfunction

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
    logw_q.delete();
    done_cnt = 0;
  endtask

  task automatic tog(input bit w);
    if (w) mic_w = ~mic_w;
    else mic = ~mic;
  endtask

  // Toggle after n cycles, so the recorder measures a half-period of n.
  task automatic edge_after(input int n, input bit w);
    repeat (n) @(negedge clock);
    tog(w);
  endtask

  task automatic preamble(input int pilots, input bit w);
    tog(w);
    repeat (pilots) edge_after(217, w);
    edge_after(67, w);
    edge_after(74, w);
  endtask

  task automatic send_bit(input bit b, input bit w);
    edge_after(b ? 171 : 86, w);
    edge_after(b ? 171 : 86, w);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit w);
    for (int i = 7; i >= 0; i--) send_bit(v[i], w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    idle(3);
    check("rst_wr_address", wr_address, 16'h0000);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_block_done", block_done, 1'b0);
    check("rst_block_len", block_len, 16'h0000);
    reset_n = 1'b1;
    rec = 1'b1;
    rec_w = 1'b1;
    idle(300);

    // Timeout after 5 bits of the first byte: nothing written.
    clear_log();
    preamble(12, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    idle(5);
    check("partial_busy", busy, 1'b1);
    idle(900);
    check("partial_nowrite", log_q.size(), 0);
    check("partial_nodone", done_cnt, 0);
    check("partial_busy_end", busy, 1'b0);

    // Short pilot then sync: rejected.
    clear_log();
    tog(1'b0);
    repeat (4) edge_after(217, 1'b0);
    idle(5);
    check("short_pilot_busy", busy, 1'b1);
    edge_after(62, 1'b0);
    idle(5);
    check("short_sync_busy", busy, 1'b0);
    idle(900);
    check("short_nowrite", log_q.size(), 0);

    // Header-style block: 0x00, 0xFF at base 0.
    clear_log();
    preamble(12, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    idle(5);
    check("hdr_busy", busy, 1'b1);
    idle(900);
    check("hdr_nwr", log_q.size(), 4);
    check("hdr_w0", log_at(0), 24'h0002_00);
    check("hdr_w1", log_at(1), 24'h0003_FF);
    check("hdr_w2", log_at(2), 24'h0000_02);
    check("hdr_w3", log_at(3), 24'h0001_00);
    check("hdr_len_consec", cyc_at(3), cyc_at(2) + 1);
    check("hdr_done_after", done_cyc, cyc_at(3) + 1);
    check("hdr_done_cnt", done_cnt, 1);
    check("hdr_block_len", block_len, 16'd2);
    check("hdr_busy_end", busy, 1'b0);

    // Second block, single byte 0xA5 at base 4.
    clear_log();
    preamble(12, 1'b0);
    send_byte(8'hA5, 1'b0);
    idle(900);
    check("blk2_nwr", log_q.size(), 3);
    check("blk2_w0", log_at(0), 24'h0006_A5);
    check("blk2_w1", log_at(1), 24'h0004_01);
    check("blk2_w2", log_at(2), 24'h0005_00);
    check("blk2_block_len", block_len, 16'd1);
    check("blk2_done_cnt", done_cnt, 1);

    // Reset mid-byte, then a fresh block restarts at address 0.
    preamble(12, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    idle(5);
    check("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wr_en", wr_en, 1'b0);
    check("mid_rst_wr_address", wr_address, 16'h0000);
    check("mid_rst_block_len", block_len, 16'h0000);
    idle(2);
    mic = 1'b1;
    reset_n = 1'b1;
    idle(300);
    clear_log();
    preamble(12, 1'b0);
    send_byte(8'h3C, 1'b0);
    idle(900);
    check("fresh_nwr", log_q.size(), 3);
    check("fresh_w0", log_at(0), 24'h0002_3C);
    check("fresh_w1", log_at(1), 24'h0000_01);
    check("fresh_w2", log_at(2), 24'h0001_00);

    // Address wrap on the instance whose base starts at 0xFFFD.
    clear_log();
    preamble(12, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(900);
    check("wrap_nwr", logw_q.size(), 5);
    check("wrap_w0", logw_at(0), 24'hFFFF_11);
    check("wrap_w1", logw_at(1), 24'h0000_22);
    check("wrap_w2", logw_at(2), 24'h0001_33);
    check("wrap_w3", logw_at(3), 24'hFFFD_03);
    check("wrap_w4", logw_at(4), 24'hFFFE_00);
    check("wrap_block_len", block_len_w, 16'd3);
    check("wrap_main_quiet", log_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
